tag_alloc: RTL

TAG_ALLOC -- requirements
Module: tag_alloc

---
 rtl/tag_alloc.sv | 75 +++++++
 1 files changed

// File: rtl/tag_alloc.sv
// tag_alloc: circular free list of destination tags with grant, retire return,
// branch-mispredict flush and sticky overflow detection.
module tag_alloc #(
   parameter int TAG_W = 5,
   parameter int DEPTH = 32
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             Alloc_req_i,
   output logic [TAG_W-1:0] Alloc_tag_o,
   output logic             Alloc_valid_o,
   output logic [TAG_W-1:0] Dispatch_Rd_tag_o,
   output logic             new_rd_tag_o,
   output logic             new_rd_tag_valid_o,
   input  logic             Retire_valid_i,
   input  logic [TAG_W-1:0] Retire_rd_tag_i,
   input  logic             Retire_branch_i,
   input  logic             Retire_branch_taken_i,
   output logic [TAG_W:0]   Free_count_o,
   output logic             Overflow_err_o
);
   localparam logic [TAG_W:0]   FULL = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] LAST = TAG_W'(DEPTH-1);
   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, disp_q, disp_d;
   logic [TAG_W:0]   count_q, count_d;
   logic             new_q, ovf_q, ovf_d;
   logic             flush, full, grant, ret, ovf_set;
   assign Alloc_tag_o        = mem_q[head_q];
   assign Alloc_valid_o      = count_q != '0;
   assign Free_count_o       = count_q;
   assign Dispatch_Rd_tag_o  = disp_q;
   assign new_rd_tag_o       = new_q;
   assign new_rd_tag_valid_o = new_q;
   assign Overflow_err_o     = ovf_q;
   always_comb begin
      flush   = Retire_valid_i & Retire_branch_i & Retire_branch_taken_i;
      full    = count_q == FULL;
      grant   = Alloc_req_i & Alloc_valid_o & ~flush;
      // a full list can still absorb a return when the head is granted the same cycle
      ret     = Retire_valid_i & ~flush & (~full | grant);
      ovf_set = Retire_valid_i & ~flush & full & ~grant;
      head_d  = grant ? ((head_q == LAST) ? '0 : head_q + 1'b1) : head_q;
      tail_d  = ret ? ((tail_q == LAST) ? '0 : tail_q + 1'b1) : tail_q;
      count_d = (grant & ~ret) ? count_q - 1'b1 : (ret & ~grant) ? count_q + 1'b1 : count_q;
      disp_d  = grant ? Alloc_tag_o : disp_q;
      ovf_d   = ovf_q | ovf_set;
   end
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= FULL;
         disp_q  <= '0;
         new_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL;
         end else begin
            if (ret) mem_q[tail_q] <= Retire_rd_tag_i;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
         end
         disp_q <= disp_d;
         new_q  <= grant;
         ovf_q  <= ovf_d;
      end
   end
endmodule
